// File: rtl/uart_modport_pkg.sv
// Shared UART definitions: frame width, FSM state encodings and baud timing.
package uart_modport_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rxState_e;

    // Integer division truncates, so odd ratios round the bit period down.
    function automatic int calcClksPerBit(input int clkFreqHz, input int baudRate);
        return clkFreqHz / baudRate;
    endfunction

endpackage

// File: rtl/uart_modport_if.sv
// UART signal bundle: UART_TX/UART_RX are the device-side views, HOST is the user side.
interface uart_modport_if;
    import uart_modport_pkg::*;

    logic [DATA_WIDTH-1:0] din;
    logic                  tx_start;
    logic                  tx;
    logic                  tx_done;
    logic                  rx;
    logic [DATA_WIDTH-1:0] dout;
    logic                  rx_done;

    modport UART_TX (
        input  din,
        input  tx_start,
        output tx,
        output tx_done
    );

    modport UART_RX (
        input  rx,
        output dout,
        output rx_done
    );

    modport HOST (
        output din,
        output tx_start,
        output rx,
        input  tx,
        input  tx_done,
        input  dout,
        input  rx_done
    );

endinterface

// File: rtl/uart_modport_rx.sv
// 8N1 receiver: synchronizes rx, finds the start bit, samples each bit mid-period.
module uart_modport_rx
    import uart_modport_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input logic             clk,
    input logic             rst,
    uart_modport_if.UART_RX rxPort
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    rxState_e              rxState_q;
    logic [1:0]            rxSync_q;
    logic [CNT_W-1:0]      rxCnt_q;
    logic [BIT_W-1:0]      rxBit_q;
    logic [DATA_WIDTH-1:0] rxShift_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rxDone_q;
    logic                  rxBit;

    assign rxBit = rxSync_q[1];

    // Synchronizer resets to idle-high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxState_q <= RX_IDLE;
            rxSync_q  <= 2'b11;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
            dout_q    <= '0;
            rxDone_q  <= 1'b0;
        end else begin
            rxSync_q <= {rxSync_q[0], rxPort.rx};
            rxDone_q <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    rxCnt_q <= '0;
                    if (!rxBit) begin
                        rxState_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxCnt_q == CNT_HALF) begin
                        rxCnt_q <= '0;
                        rxBit_q <= '0;
                        rxState_q <= rxBit ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt_q <= rxCnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rxCnt_q == CNT_LAST) begin
                        rxCnt_q   <= '0;
                        rxShift_q <= {rxBit, rxShift_q[DATA_WIDTH-1:1]};
                        if (rxBit_q == BIT_LAST) begin
                            rxState_q <= RX_STOP;
                        end else begin
                            rxBit_q <= rxBit_q + 1'b1;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rxCnt_q == CNT_LAST) begin
                        rxCnt_q <= '0;
                        if (rxBit) begin
                            dout_q    <= rxShift_q;
                            rxDone_q  <= 1'b1;
                            rxState_q <= RX_IDLE;
                        end else begin
                            rxState_q <= RX_WAIT_IDLE;
                        end
                    end else begin
                        rxCnt_q <= rxCnt_q + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rxBit) begin
                        rxState_q <= RX_IDLE;
                    end
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    assign rxPort.dout    = dout_q;
    assign rxPort.rx_done = rxDone_q;

endmodule

// File: rtl/uart_modport.sv
// Full-duplex 8N1 UART top: transmit FSM lives here, receiver is a sub-module.
module uart_modport
    import uart_modport_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input logic             clk,
    input logic             rst,
    uart_modport_if.UART_TX txPort,
    uart_modport_if.UART_RX rxPort
);

    localparam int CLKS_PER_BIT = calcClksPerBit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_badBaud
            $error("uart_modport: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    txState_e              txState_q;
    logic [CNT_W-1:0]      txCnt_q;
    logic [BIT_W-1:0]      txBit_q;
    logic [DATA_WIDTH-1:0] txShift_q;
    logic                  tx_q;
    logic                  txDone_q;

    // IDLE accepts during the tx_done cycle, so back-to-back frames need no extra idle time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txState_q <= TX_IDLE;
            txCnt_q   <= '0;
            txBit_q   <= '0;
            txShift_q <= '0;
            tx_q      <= 1'b1;
            txDone_q  <= 1'b0;
        end else begin
            txDone_q <= 1'b0;
            case (txState_q)
                TX_IDLE: begin
                    tx_q    <= 1'b1;
                    txCnt_q <= '0;
                    if (txPort.tx_start) begin
                        txShift_q <= txPort.din;
                        tx_q      <= 1'b0;
                        txState_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (txCnt_q == CNT_LAST) begin
                        txCnt_q   <= '0;
                        txBit_q   <= '0;
                        tx_q      <= txShift_q[0];
                        txShift_q <= txShift_q >> 1;
                        txState_q <= TX_DATA;
                    end else begin
                        txCnt_q <= txCnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (txCnt_q == CNT_LAST) begin
                        txCnt_q <= '0;
                        if (txBit_q == BIT_LAST) begin
                            tx_q      <= 1'b1;
                            txState_q <= TX_STOP;
                        end else begin
                            txBit_q   <= txBit_q + 1'b1;
                            tx_q      <= txShift_q[0];
                            txShift_q <= txShift_q >> 1;
                        end
                    end else begin
                        txCnt_q <= txCnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (txCnt_q == CNT_LAST) begin
                        txCnt_q   <= '0;
                        tx_q      <= 1'b1;
                        txDone_q  <= 1'b1;
                        txState_q <= TX_IDLE;
                    end else begin
                        txCnt_q <= txCnt_q + 1'b1;
                    end
                end
                default: txState_q <= TX_IDLE;
            endcase
        end
    end

    assign txPort.tx      = tx_q;
    assign txPort.tx_done = txDone_q;

    uart_modport_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rxPort (rxPort)
    );

endmodule

// File: tb/tb_uart_modport.sv
// Self-checking bench for uart_modport at 10 clocks per bit, with an rx_done scoreboard.
module tb_uart_modport;

    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst;
    logic loopback;
    logic rxDrive;

    uart_modport_if uif ();

    assign uif.rx = loopback ? uif.tx : rxDrive;

    uart_modport #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD_RATE   (100_000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .txPort (uif),
        .rxPort (uif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txDoneCount = 0;
    int rxDoneCount = 0;
    logic [7:0] rxExpQ[$];
    logic [7:0] expByte;

    // Every received byte is popped against the bytes queued when they were sent.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (uif.tx_done === 1'b1) txDoneCount++;
            if (uif.rx_done === 1'b1) begin
                rxDoneCount++;
                checks++;
                if (rxExpQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rx_unexpected: got dout=%h, required no rx_done", uif.dout);
                end else begin
                    expByte = rxExpQ.pop_front();
                    if (uif.dout !== expByte) begin
                        errors++;
                        $display("[TB] FAIL rx_data: got %h, required %h", uif.dout, expByte);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        uif.din      = b;
        uif.tx_start = 1'b1;
        @(negedge clk);
        uif.tx_start = 1'b0;
    endtask

    task automatic waitTxDone(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (uif.tx_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic driveRxFrame(input logic [7:0] b, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxDrive = bits[k];
            repeat (CPB) @(negedge clk);
        end
        rxDrive = 1'b1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        loopback     = 1'b0;
        rxDrive      = 1'b1;
        uif.din      = 8'h00;
        uif.tx_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            uif.din      = 8'($urandom);
            uif.tx_start = 1'($urandom);
            @(negedge clk);
            checks++;
            if (uif.tx !== 1'b1 || uif.tx_done !== 1'b0 || uif.rx_done !== 1'b0 || uif.dout !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_state: got tx=%b tx_done=%b rx_done=%b dout=%h, required 1 0 0 00",
                         uif.tx, uif.tx_done, uif.rx_done, uif.dout);
            end
        end
        uif.tx_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx_a5();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        sendByte(8'hA5);
        for (int j = 0; j < 10 * CPB; j++) begin
            checks++;
            if (uif.tx !== frame[j / CPB] || uif.tx_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL tx_a5_bit cycle %0d: got tx=%b tx_done=%b, required tx=%b tx_done=0",
                         j, uif.tx, uif.tx_done, frame[j / CPB]);
            end
            @(negedge clk);
        end
        checks++;
        if (uif.tx_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_a5_done: got %b at cycle 100, required 1", uif.tx_done);
        end
        @(negedge clk);
        checks++;
        if (uif.tx_done !== 1'b0 || uif.tx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tx_a5_after: got tx_done=%b tx=%b, required 0 1", uif.tx_done, uif.tx);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] nextBytes[2];
        int startRx;
        bit seen;
        nextBytes[0] = 8'h00;
        nextBytes[1] = 8'hFF;
        loopback = 1'b1;
        repeat (3) @(negedge clk);
        startRx = rxDoneCount;
        rxExpQ.push_back(8'h3C);
        rxExpQ.push_back(8'h00);
        rxExpQ.push_back(8'hFF);
        sendByte(8'h3C);
        for (int f = 0; f < 2; f++) begin
            waitTxDone(12 * CPB, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("[TB] FAIL loop_tx_done frame %0d: got no tx_done, required one", f);
            end
            uif.din      = nextBytes[f];
            uif.tx_start = 1'b1;
            @(negedge clk);
            uif.tx_start = 1'b0;
            checks++;
            if (uif.tx !== 1'b0) begin
                errors++;
                $display("[TB] FAIL loop_no_gap frame %0d: got tx=%b, required start bit 0", f + 1, uif.tx);
            end
        end
        waitTxDone(12 * CPB, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL loop_last_done: got no tx_done, required one");
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rxDoneCount - startRx != 3) begin
            errors++;
            $display("[TB] FAIL loop_rx_count: got %0d, required 3", rxDoneCount - startRx);
        end
    endtask

    task automatic test_busy_ignore();
        logic [9:0] frame;
        int startTx;
        int startRx;
        frame    = {1'b1, 8'h5A, 1'b0};
        loopback = 1'b1;
        startTx  = txDoneCount;
        startRx  = rxDoneCount;
        rxExpQ.push_back(8'h5A);
        sendByte(8'h5A);
        for (int j = 0; j < 10 * CPB; j++) begin
            if (j == 35) begin
                uif.din      = 8'h11;
                uif.tx_start = 1'b1;
            end
            if (j == 36) uif.tx_start = 1'b0;
            if (j % CPB == CPB / 2) begin
                checks++;
                if (uif.tx !== frame[j / CPB]) begin
                    errors++;
                    $display("[TB] FAIL busy_bit %0d: got %b, required %b", j / CPB, uif.tx, frame[j / CPB]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (uif.tx_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_done: got %b at cycle 100, required 1", uif.tx_done);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (uif.tx !== 1'b1 || txDoneCount - startTx != 1 || rxDoneCount - startRx != 1) begin
            errors++;
            $display("[TB] FAIL busy_single: got tx=%b tx_done count=%0d rx_done count=%0d, required 1 1 1",
                     uif.tx, txDoneCount - startTx, rxDoneCount - startRx);
        end
    endtask

    task automatic test_rx_errors();
        int startRx;
        loopback = 1'b0;
        rxDrive  = 1'b1;
        repeat (5) @(negedge clk);
        startRx = rxDoneCount;
        rxDrive = 1'b0;
        repeat (3) @(negedge clk);
        rxDrive = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (rxDoneCount != startRx || uif.dout !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL rx_glitch: got rx_done count=%0d dout=%h, required 0 5a",
                     rxDoneCount - startRx, uif.dout);
        end
        driveRxFrame(8'h77, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (rxDoneCount != startRx || uif.dout !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL rx_framing: got rx_done count=%0d dout=%h, required 0 5a",
                     rxDoneCount - startRx, uif.dout);
        end
        rxExpQ.push_back(8'h42);
        driveRxFrame(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (rxDoneCount - startRx != 1 || uif.dout !== 8'h42) begin
            errors++;
            $display("[TB] FAIL rx_recover: got rx_done count=%0d dout=%h, required 1 42",
                     rxDoneCount - startRx, uif.dout);
        end
    endtask

    task automatic test_midframe_reset();
        int startTx;
        int startRx;
        bit seen;
        loopback = 1'b1;
        repeat (3) @(negedge clk);
        startTx = txDoneCount;
        startRx = rxDoneCount;
        sendByte(8'h96);
        repeat (35) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (uif.tx !== 1'b1 || uif.tx_done !== 1'b0 || uif.rx_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async: got tx=%b tx_done=%b rx_done=%b, required 1 0 0",
                     uif.tx, uif.tx_done, uif.rx_done);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (120) @(negedge clk);
        checks++;
        if (txDoneCount != startTx || rxDoneCount != startRx || uif.dout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_abort: got tx_done count=%0d rx_done count=%0d dout=%h, required 0 0 00",
                     txDoneCount - startTx, rxDoneCount - startRx, uif.dout);
        end
        rxExpQ.push_back(8'hC3);
        sendByte(8'hC3);
        waitTxDone(12 * CPB, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL midreset_tx_done: got no tx_done, required one");
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rxDoneCount - startRx != 1 || uif.dout !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL midreset_clean: got rx_done count=%0d dout=%h, required 1 c3",
                     rxDoneCount - startRx, uif.dout);
        end
    endtask

    initial begin
        $display("[TB] uart_modport bench starting");
        test_reset();
        test_tx_a5();
        test_loopback();
        test_busy_ignore();
        test_rx_errors();
        test_midframe_reset();
        checks++;
        if (rxExpQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d bytes pending, required 0", rxExpQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
